// File: rtl/recog_ctrl_pkg.sv
// Shared types and helpers for the recognizer frame controller.
// Build option: RECOG_MATCH_MAP_EN adds the per-bit match_map result port.
package recog_ctrl_pkg;

   localparam int unsigned DEFAULT_DATA_W = 20;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StShift,
      StDrain,
      StDone
   } state_e;

   // Requested lengths beyond the frame buffer are truncated to the buffer size.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      return (len > max_len) ? max_len : len;
   endfunction

endpackage

// File: rtl/recog_frame_shifter.sv
// Frame buffer for the recognizer controller: holds the latched frame and
// length, walks the bit index and presents the current bit on the serial line.
// Build option: RECOG_MATCH_MAP_EN (no effect in this file).
module recog_frame_shifter
   import recog_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [CNT_W-1:0]  len_i,
   input  logic              advance_i,
   input  logic              shift_en_i,
   output logic              bit_o,
   output logic [CNT_W-1:0]  idx_o,
   output logic              last_o
);

   logic [DATA_W-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  idx_q, idx_d;

   // Next-state: load restarts the walk at bit 0, advance steps one bit.
   always_comb begin
      frame_d = frame_q;
      len_d   = len_q;
      idx_d   = idx_q;
      if (load_i) begin
         frame_d = data_i;
         len_d   = len_i;
         idx_d   = '0;
      end else if (advance_i) begin
         idx_d = idx_q + CNT_W'(1);
      end
   end

   // Frame, length and index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q <= '0;
         len_q   <= '0;
         idx_q   <= '0;
      end else begin
         frame_q <= frame_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
      end
   end

   // Serial line is held low outside the shift phase; len_q=0 never flags last.
   always_comb begin
      bit_o  = shift_en_i & frame_q[idx_q];
      idx_o  = idx_q;
      last_o = (idx_q == len_q - CNT_W'(1));
   end

endmodule

// File: rtl/recog_frame_ctrl.sv
// Sequencer for the serial pattern recognizer (at least two 1s, odd number of 0s).
// Clears the recognizer, shifts a latched frame LSB-first, samples F after each
// bit and reports the match count, final F and a done pulse.
// Build option: RECOG_MATCH_MAP_EN adds match_map (bit k = F after bit k).
module recog_frame_ctrl
   import recog_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W,
   parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CNT_W-1:0]  len,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              final_f,
   output logic              rec_x,
   output logic              rec_clr,
`ifdef RECOG_MATCH_MAP_EN
   output logic [DATA_W-1:0] match_map,
`endif
   input  logic              rec_f
);

   state_e           state_q, state_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic             final_f_q, final_f_d;
`ifdef RECOG_MATCH_MAP_EN
   logic [DATA_W-1:0] match_map_q, match_map_d;
   logic [CNT_W-1:0]  sample_idx;
`endif

   logic             load;
   logic             sample_en;
   logic [CNT_W-1:0] len_clamped;
   logic             shf_bit;
   logic [CNT_W-1:0] shf_idx;
   logic             shf_last;

   // Clamp the requested length to the frame buffer size.
   always_comb begin
      len_clamped = CNT_W'(clamp_len(32'(len), DATA_W));
   end

   recog_frame_shifter #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .data_i     (data_in),
      .len_i      (len_clamped),
      .advance_i  ((state_q == StShift) && !shf_last),
      .shift_en_i (state_q == StShift),
      .bit_o      (shf_bit),
      .idx_o      (shf_idx),
      .last_o     (shf_last)
   );

   // FSM next-state, F sampling and result accumulation.
   // F is registered in the recognizer, so the F for bit k is seen one cycle
   // after bit k was driven: during the next SHIFT cycle, or DRAIN for the last bit.
   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      match_cnt_d = match_cnt_q;
      final_f_d   = final_f_q;
      load        = 1'b0;
      sample_en   = 1'b0;
`ifdef RECOG_MATCH_MAP_EN
      match_map_d = match_map_q;
      sample_idx  = shf_idx;
`endif
      unique case (state_q)
         StIdle: begin
            // done_q high means this is the done cycle: a start here is dropped.
            if (start && !done_q) begin
               load        = 1'b1;
               busy_d      = 1'b1;
               match_cnt_d = '0;
               final_f_d   = 1'b0;
`ifdef RECOG_MATCH_MAP_EN
               match_map_d = '0;
`endif
               state_d     = (len_clamped == '0) ? StDone : StClear;
            end
         end
         StClear: state_d = StShift;
         StShift: begin
            if (shf_idx != '0) begin
               sample_en = 1'b1;
`ifdef RECOG_MATCH_MAP_EN
               sample_idx = shf_idx - CNT_W'(1);
`endif
            end
            if (shf_last) state_d = StDrain;
         end
         StDrain: begin
            sample_en = 1'b1;
            final_f_d = rec_f;
            state_d   = StDone;
         end
         StDone: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (sample_en && rec_f) begin
         if (match_cnt_q != CNT_W'(DATA_W)) match_cnt_d = match_cnt_q + CNT_W'(1);
`ifdef RECOG_MATCH_MAP_EN
         match_map_d[sample_idx] = 1'b1;
`endif
      end
   end

   // State and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         match_cnt_q <= '0;
         final_f_q   <= 1'b0;
`ifdef RECOG_MATCH_MAP_EN
         match_map_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         match_cnt_q <= match_cnt_d;
         final_f_q   <= final_f_d;
`ifdef RECOG_MATCH_MAP_EN
         match_map_q <= match_map_d;
`endif
      end
   end

   // Outputs come straight from flops so they only move on rising clk.
   always_comb begin
      busy      = busy_q;
      done      = done_q;
      match_cnt = match_cnt_q;
      final_f   = final_f_q;
      rec_x     = shf_bit;
      rec_clr   = (state_q == StClear);
`ifdef RECOG_MATCH_MAP_EN
      match_map = match_map_q;
`endif
   end

endmodule

// File: tb/tb_recog_frame_ctrl.sv
// Self-checking bench for recog_frame_ctrl with a behavioural recognizer
// (at least two 1s and an odd number of 0s, registered Moore output).
// Build option: RECOG_MATCH_MAP_EN also checks match_map.
module tb_recog_frame_ctrl;

   localparam int unsigned DW = 20;
   localparam int unsigned CW = $clog2(DW + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [DW-1:0] data_in;
   logic [CW-1:0] len;
   logic          busy, done, final_f, rec_x, rec_clr, rec_f;
   logic [CW-1:0] match_cnt;
`ifdef RECOG_MATCH_MAP_EN
   logic [DW-1:0] match_map;
`endif

   recog_frame_ctrl #(
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .data_in   (data_in),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt),
      .final_f   (final_f),
      .rec_x     (rec_x),
      .rec_clr   (rec_clr),
`ifdef RECOG_MATCH_MAP_EN
      .match_map (match_map),
`endif
      .rec_f     (rec_f)
   );

   always #5 clk = ~clk;

   // Recognizer model: ones count saturating at 2, parity of zeros.
   logic [1:0] ones_q;
   logic       zpar_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst || rec_clr) begin
         ones_q <= 2'd0;
         zpar_q <= 1'b0;
      end else if (rec_x) begin
         if (ones_q != 2'd2) ones_q <= ones_q + 2'd1;
      end else begin
         zpar_q <= ~zpar_q;
      end
   end
   assign rec_f = (ones_q == 2'd2) && zpar_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            edge_cyc;
      int            lat;
      int            cnt;
      int            fin;
      logic [DW-1:0] map;
      int            clr;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   n_pass  = 0;
   int   n_total = 0;
   int   busy_cnt = 0;
   int   clr_cnt  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   task automatic push_exp(input int edge_c, input int lat, input int cnt, input int fin,
                           input logic [DW-1:0] map, input int clr);
      exp_t x;
      x.edge_cyc = edge_c;
      x.lat      = lat;
      x.cnt      = cnt;
      x.fin      = fin;
      x.map      = map;
      x.clr      = clr;
      sb_q.push_back(x);
   endtask

   // Monitor: compares each done pulse against the oldest expectation.
   always @(negedge clk) begin
      if (rst) begin
         busy_cnt = 0;
         clr_cnt  = 0;
      end else begin
         if (rec_clr) begin
            clr_cnt++;
            check("rec_x_during_clr", 32'(rec_x), 32'd0);
         end
         if (busy) busy_cnt++;
         if (done) begin
            if (sb_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("latency", 32'(cyc - e.edge_cyc), 32'(e.lat));
               check("match_cnt", 32'(match_cnt), 32'(e.cnt));
               check("final_f", 32'(final_f), 32'(e.fin));
               check("busy_cycles", 32'(busy_cnt), 32'(e.lat));
               check("busy_at_done", 32'(busy), 32'd0);
               check("rec_clr_pulses", 32'(clr_cnt), 32'(e.clr));
`ifdef RECOG_MATCH_MAP_EN
               check("match_map", 32'(match_map), 32'(e.map));
`endif
            end
            busy_cnt = 0;
            clr_cnt  = 0;
         end
      end
   end

   task automatic wait_drain();
      for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
      check("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic frame(input int l, input logic [DW-1:0] d, input int lat, input int cnt,
                        input int fin, input logic [DW-1:0] map, input int clr);
      @(negedge clk);
      len     = CW'(l);
      data_in = d;
      start   = 1'b1;
      push_exp(cyc + 1, lat, cnt, fin, map, clr);
      @(negedge clk);
      start = 1'b0;
      wait_drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = '0;
      len     = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_match_cnt", 32'(match_cnt), 32'd0);
      check("rst_final_f", 32'(final_f), 32'd0);
      check("rst_rec_x", 32'(rec_x), 32'd0);
      check("rst_rec_clr", 32'(rec_clr), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // 1: sends 1,1,0,0 -> F 0,0,1,0
      frame(4, 20'h00003, 7, 1, 0, 20'h00004, 1);
      repeat (3) @(negedge clk);
      check("hold_match_cnt", 32'(match_cnt), 32'd1);

      // 2: sends 0,1,1 -> F 0,0,1
      frame(3, 20'h00006, 6, 1, 1, 20'h00004, 1);
      check("hold_final_f", 32'(final_f), 32'd1);

      // 3: all ones, no zeros -> F never 1
      frame(20, 20'hFFFFF, 23, 0, 0, 20'h00000, 1);

      // 4: empty frame
      frame(0, 20'h12345, 1, 0, 0, 20'h00000, 0);

      // 5: second start while busy, then reset mid-frame
      @(negedge clk);
      len     = CW'(20);
      data_in = 20'b1111_0000_0001_1100_0100;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("t5_busy_mid", 32'(busy), 32'd1);
      check("t5_single_clear", 32'(clr_cnt), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      check("t5_rst_rec_x", 32'(rec_x), 32'd0);
      check("t5_rst_rec_clr", 32'(rec_clr), 32'd0);
      check("t5_rst_match_cnt", 32'(match_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);

      // 6: len 25 clamps to 20; sends 1,1 then 18 zeros -> F=1 after bits 2,4..18
      @(negedge clk);
      len     = CW'(25);
      data_in = 20'h00003;
      start   = 1'b1;
      push_exp(cyc + 1, 23, 9, 0, 20'h55554, 1);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 60 && !done; i++) @(negedge clk);
      check("t6_done_seen", 32'(done), 32'd1);
      // Start raised in the done cycle: dropped at the next edge, taken one later.
      len     = CW'(3);
      data_in = 20'h00003;
      start   = 1'b1;
      push_exp(cyc + 2, 6, 1, 1, 20'h00004, 1);
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
